// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end and the microcode
// sequencer: fetch FSM states, instruction width, opcode field position and
// the halt opcode.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } fetch_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] HALT_OPCODE = 6'h3F;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Fetch wait counter. Counts FETCH cycles without mem_ready and flags the
// cycle in which the TIMEOUT_CYCLES-th consecutive wait cycle is running.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   clear_i    hold the count at zero (fetch not in progress)
//   count_en_i fetch in progress and memory not ready this cycle
//   expired_o  current cycle is wait cycle number TIMEOUT_CYCLES
//
// TIMEOUT_CYCLES must be at least 1.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of wait cycles already completed, so the limit
  // cycle is the one that starts with TIMEOUT_CYCLES-1 behind it.
  assign expired_o = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/dispatch front end for the microcoded MIPS core.
// Fetches 32-bit instructions over a req/ready handshake, presents the opcode
// to the sequencer, owns the PC (sequential, branch redirect) and stops on
// the halt opcode or a misaligned branch target.
//
// Build option: FETCH_TIMEOUT_EN -- abort a fetch with fault after
// TIMEOUT_CYCLES cycles without mem_ready.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   seg_end                   sequencer segment finished, fetch next
//   branch_taken/target       redirect, sampled with seg_end
//   mem_rd/mem_addr           read request and address (= pc)
//   mem_rdata/mem_ready       read data and completion
//   opcode/instr              current instruction and its opcode field
//   pc                        address of the next fetch
//   stall/halted/fault        sequencer hold, fetch stopped, error stop
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC       = '0,
  parameter int unsigned        TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seg_end,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               stall,
  output logic               halted,
  output logic               fault
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               fault_q, fault_d;
  // Low from reset until the first clk edge after it: holds off the request
  // so a mem_ready left over from a fetch cut by reset is never accepted.
  logic               armed_q;
  logic               fetching;
  logic               timeout_hit;

  assign fetching = (state_q == FETCH) && armed_q;

`ifdef FETCH_TIMEOUT_EN
  logic tmo_expired;

  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (!fetching),
    .count_en_i (fetching && !mem_ready),
    .expired_o  (tmo_expired)
  );

  // mem_ready in the limit cycle wins over the timeout.
  assign timeout_hit = fetching && !mem_ready && tmo_expired;
`else
  assign timeout_hit = 1'b0;

  // A zero limit would never expire; this is the only use of the parameter
  // in a build without the timeout.
  if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout
  end
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      FETCH: begin
        if (fetching && mem_ready) begin
          instr_d = mem_rdata;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = (mem_rdata[OPC_MSB:OPC_LSB] == HALT_OPCODE) ? HALT : EXEC;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end
      EXEC: begin
        if (seg_end) begin
          state_d = FETCH;
          if (branch_taken) begin
            pc_d = branch_target;
            if (branch_target[1:0] != 2'b00) begin
              fault_d = 1'b1;
              state_d = HALT;
            end
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      fault_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      armed_q <= 1'b1;
    end
  end

  assign mem_rd   = fetching;
  assign mem_addr = pc_q;
  assign instr    = instr_q;
  assign opcode   = instr_q[OPC_MSB:OPC_LSB];
  assign pc       = pc_q;
  // Stall through the seg_end cycle so the old opcode is never re-dispatched.
  assign stall    = (state_q != EXEC) || seg_end;
  assign halted   = (state_q == HALT);
  assign fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        seg_end;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [5:0]  opcode;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        stall;
  logic        halted;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  instr_fetch_unit #(
    .ADDR_W         (32),
    .RESET_PC       (32'h0),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .seg_end       (seg_end),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .opcode        (opcode),
    .instr         (instr),
    .pc            (pc),
    .stall         (stall),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Return one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges, release it, and advance to the first request cycle.
  task automatic do_reset();
    rst = 1'b1;
    seg_end = 1'b0;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    #2;
    rst = 1'b0;
    tick();
  endtask

  // Serve one fetch: check the request, hold off for 'waits' cycles, then return data.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
    exp_t e;
    int   n = 0;
    while (!mem_rd && n < 20) begin
      tick();
      n++;
    end
    check("fetch_req", mem_rd, 1);
    check("fetch_addr", mem_addr, addr);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      tick();
      check("fetch_hold", {mem_rd, mem_addr}, {1'b1, addr});
    end
    mem_rdata = data;
    mem_ready = 1'b1;
    sb.push_back('{instr: data, pc: addr + 32'd4});
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    e = sb.pop_front();
    check("fetch_instr", instr, e.instr);
    check("fetch_opcode", opcode, e.instr[31:26]);
    check("fetch_pc", pc, e.pc);
  endtask

  initial begin
    rst = 1'b1;
    seg_end = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_instr", instr, 0);
    check("rst_opcode", opcode, 0);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_stall", stall, 1);

    // No request until the first clk after release; zero-wait first fetch.
    rst = 1'b0;
    #1;
    check("pre_edge_mem_rd", mem_rd, 0);
    tick();
    do_fetch(32'h0, 32'h8C01_0004, 0);
    check("lw_opcode", opcode, 6'h23);
    check("exec_stall", stall, 0);
    check("exec_mem_rd", mem_rd, 0);

    // branch_taken without seg_end is ignored.
    branch_taken = 1'b1;
    branch_target = 32'h80;
    tick();
    check("lone_branch_pc", pc, 32'h4);
    check("lone_branch_state", {stall, mem_rd}, 2'b00);

    // Taken branch to 0x40, three wait cycles.
    seg_end = 1'b1;
    branch_target = 32'h40;
    #1;
    check("seg_end_stall", stall, 1);
    tick();
    seg_end = 1'b0;
    branch_taken = 1'b0;
    do_fetch(32'h40, 32'hAC02_0008, 3);
    check("sw_opcode", opcode, 6'h2B);

    // Sequential fetch.
    seg_end = 1'b1;
    tick();
    seg_end = 1'b0;
    do_fetch(32'h44, 32'h2011_0005, 0);

    // Halt opcode.
    seg_end = 1'b1;
    tick();
    seg_end = 1'b0;
    do_fetch(32'h48, 32'hFC00_0000, 1);
    check("halt_halted", halted, 1);
    check("halt_opcode", opcode, 6'h3F);
    check("halt_mem_rd", mem_rd, 0);
    check("halt_stall", stall, 1);
    check("halt_fault", fault, 0);
    seg_end = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_sticky", {mem_rd, halted, instr, pc}, {1'b0, 1'b1, 32'hFC00_0000, 32'h4C});
    end

    // Misaligned branch target.
    do_reset();
    do_fetch(32'h0, 32'h8C01_0004, 0);
    seg_end = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h42;
    tick();
    seg_end = 1'b0;
    branch_taken = 1'b0;
    check("misalign_fault", fault, 1);
    check("misalign_halted", halted, 1);
    for (int i = 0; i < 3; i++) begin
      check("misalign_no_rd", mem_rd, 0);
      tick();
    end

    // Reset in the middle of a fetch; a late mem_ready must be ignored.
    do_reset();
    do_fetch(32'h0, 32'h8C01_0004, 0);
    seg_end = 1'b1;
    tick();
    seg_end = 1'b0;
    check("midfetch_req", {mem_rd, mem_addr}, {1'b1, 32'h4});
    rst = 1'b1;
    #1;
    check("midfetch_rst_rd", mem_rd, 0);
    tick();
    rst = 1'b0;
    mem_rdata = 32'hFC00_0000;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("midfetch_instr", instr, 0);
    check("midfetch_halted", halted, 0);
    do_fetch(32'h0, 32'h2011_0005, 1);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: fault after exactly four FETCH cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tmo_waiting", {mem_rd, fault}, 2'b10);
    end
    tick();
    check("tmo_fault", fault, 1);
    check("tmo_halted", halted, 1);
    check("tmo_mem_rd", mem_rd, 0);

    // Ready in the limit cycle completes normally.
    do_reset();
    do_fetch(32'h0, 32'h8C01_0004, 3);
    check("tmo_edge_fault", fault, 0);
    check("tmo_edge_halted", halted, 0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch/dispatch front end for the microcoded MIPS core.
- Consumes the microcode sequencer's end-of-segment request (control bit 0).
- Fetches the next 32-bit instruction from memory over a req/ready handshake and presents the 6-bit opcode the sequencer dispatches on.
- Holds the sequencer stalled until the opcode is valid, and owns the PC, including branch redirect and halt.

Parameters:
- ADDR_W, 32: PC / memory address width.
- RESET_PC, 0: first fetch address after reset.
- TIMEOUT_CYCLES, 255: maximum wait for mem_ready. Only used with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_end  in  1  sequencer control bit 0: current microcode segment finished, fetch next instruction.
- branch_taken  in  1  sampled with seg_end: redirect the next fetch.
- branch_target  in  ADDR_W  redirect address, valid when branch_taken.
- mem_rd  out  1  memory read request.
- mem_addr  out  ADDR_W  read address (= pc while mem_rd).
- mem_rdata  in  32  read data, valid when mem_ready.
- mem_ready  in  1  read completes this cycle.
- opcode  out  6  instr[31:26] of the current instruction, to the sequencer.
- instr  out  32  current instruction register.
- pc  out  ADDR_W  address of the next fetch.
- stall  out  1  sequencer must not advance or dispatch.
- halted  out  1  fetch stopped (halt opcode or fault).
- fault  out  1  misaligned target (or timeout, see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - state=FETCH, pc=RESET_PC.
  - instr=0, opcode=0, halted=0, fault=0.
  - mem_rd drops asynchronously; the first fetch starts on the first clk after rst deasserts.
  - Any mem_ready from a fetch cut off by reset is ignored.
- States: FETCH, EXEC, HALT.
- FETCH:
  - mem_rd=1 and mem_addr=pc, held stable until mem_ready is sampled high.
  - On mem_ready:
    - instr<=mem_rdata, opcode<=mem_rdata[31:26], pc<=pc+4 (wraps modulo 2^ADDR_W).
    - If mem_rdata[31:26]==6'h3F: go to HALT.
    - Otherwise: go to EXEC.
  - Minimum fetch latency: 1 cycle (ready on the first request cycle), i.e. seg_end to new opcode in 2 edges.
- EXEC:
  - mem_rd=0; opcode and instr held stable.
  - On seg_end, next state is FETCH.
    - If branch_taken: pc<=branch_target.
    - If branch_taken and branch_target[1:0]!=0: fault<=1, go to HALT; no fetch is issued.
  - branch_taken without seg_end is ignored.
- HALT:
  - mem_rd=0, halted=1, stall=1; opcode keeps its last value (6'h3F on a halt-opcode stop).
  - Left only by rst.
- stall (combinational): 1 when state!=EXEC, or when state==EXEC and seg_end==1. The sequencer therefore never dispatches on a stale opcode in the seg_end cycle.
- mem_ready outside FETCH is ignored. mem_rdata is sampled only on the mem_ready edge.
- seg_end outside EXEC is ignored; there is no request queueing.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - An 8+ bit wait counter clears on entry to FETCH and increments each FETCH cycle without mem_ready.
  - When the count reaches TIMEOUT_CYCLES and mem_ready is still low: mem_rd<=0, fault<=1, go to HALT.
  - mem_ready in the same cycle as the limit wins; the fetch completes normally.
- Not defined: FETCH waits indefinitely; fault only reports misaligned branch targets.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {FETCH, EXEC, HALT};
  - HALT_OPCODE = 6'h3F;
  - OPC_MSB = 31, OPC_LSB = 26;
  - INSTR_W = 32.
- The sequencer shares the halt opcode and opcode width through this package.
- One sub-module, fetch_timeout_ctr, instantiated only under FETCH_TIMEOUT_EN. All else is flat.

Test Plan:
- Reset, then mem_ready=1 with rdata=32'h8C010004 on the first request -> mem_addr=0, then opcode=6'h23, pc=4, stall=0 one edge later.
- In EXEC, seg_end=1, branch_taken=1, target=32'h40; memory returns 32'hAC020008 after 3 wait cycles -> stall=1 in the seg_end cycle; mem_addr=32'h40 held for 4 cycles; then opcode=6'h2B, pc=32'h44.
- Fetch returns 32'hFC000000 -> halted=1, opcode=6'h3F, mem_rd=0. Further seg_end/mem_ready cause no change until rst.
- seg_end with branch_taken=1, target=32'h42 -> fault=1, halted=1, no mem_rd pulse.
- Assert rst mid-FETCH with mem_ready arriving 1 cycle later -> mem_rd=0 immediately, instr stays 0, next fetch is from RESET_PC.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready stuck at 0 -> fault=1 and HALT after exactly 4 FETCH cycles. Repeat with ready on cycle 4 -> normal completion.
